if_id_reg: RTL
==============

Name: if_id_reg

Overview:
- IF/ID pipeline register directly downstream of the fetch unit; latches the fetched instruction and PC into the Decode stage.
- Also tags fetch-side address exceptions (AdEL on the instruction address) and carries the branch-delay-slot flag forward for EPC/Cause.BD.
- Handles the three control events: stall hold, exception-entry flush, and ERET flush.

Parameters:
- START_PC, 32'h0000_3000, PCD value after reset.
- HANDLER_PC, 32'h0000_4180, PCD value loaded on exception-entry flush.
- IM_LO, 32'h0000_3000, lowest legal instruction address.
- IM_HI, 32'h0000_4FFF, highest legal instruction byte address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- EN  input  1  stage enable; 0 = stall (hold contents).
- Req  input  1  exception/interrupt entry from CP0; flushes this stage.
- ERETFlush  input  1  ERET in D/E; kill the wrong-path fetched instruction.
- InstrF  input  32  instruction from fetch.
- PCF  input  32  fetch PC.
- isBDF  input  1  fetched instruction sits in a branch delay slot.
- InstrD  output  32  registered instruction.
- PCD  output  32  registered PC.
- PC8D  output  32  PCD+8, combinational from PCD, for jal/jalr link.
- ExcCodeD  output  5  registered fetch exception code; 0 = none.
- isBDD  output  1  registered delay-slot flag.
- ValidD  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- All state changes happen on posedge clk. The only exception is reset, which is asynchronous on posedge reset.
- Reset values:
  - InstrD=0, PCD=START_PC, PC8D=START_PC+8.
  - ExcCodeD=0, isBDD=0, ValidD=0.
- Fetch exception check (combinational on PCF):
  - AdEL when PCF[1:0]!=0, PCF<IM_LO, or PCF>IM_HI.
  - ExcCode AdEL = 5'd4.
- Update priority, highest first:
  1. reset.
  2. Req=1: InstrD=0, PCD=HANDLER_PC, ExcCodeD=0, isBDD=0, ValidD=0. Applies regardless of EN.
  3. EN=0: hold every register, including ValidD and ExcCodeD.
  4. ERETFlush=1 (with EN=1): InstrD=0, PCD=PCF, ExcCodeD=0, isBDD=0, ValidD=0.
  5. Normal load (EN=1): PCD=PCF, isBDD=isBDF, ValidD=1.
     - On AdEL: InstrD=0 (never forward data from an illegal address), ExcCodeD=4.
     - Otherwise: InstrD=InstrF, ExcCodeD=0.
- Latency: exactly one cycle from F to D. No combinational path from any input to any output; PC8D depends only on PCD.
- Bubbles keep a meaningful PCD, so a later exception in the bubble's shadow still sees a sane EPC candidate.
- Reset mid-stall clears everything immediately; the first edge after reset deasserts performs a normal load if EN=1.
- Back-to-back stalls may last any number of cycles; contents stay bit-exact throughout.
- Arithmetic: PC8D = PCD+32'd8, modulo 2^32 (wrap is permitted, no special case).

Decomposition:
- Shared constants header holds:
  - Exception codes: EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - START_PC and HANDLER_PC, so that CP0, NPC and this block agree.
- One natural sub-module: fetch_exc_check (PCF -> 5-bit ExcCode). It is purely combinational and reusable by the M-stage for data-address checks given different bounds.

Test Plan:
1. Reset, then release with EN=1, PCF=0x3000, InstrF=0x3c010001 -> next edge: InstrD=0x3c010001, PCD=0x3000, PC8D=0x3008, ValidD=1, ExcCodeD=0.
2. EN=0 for 3 cycles while PCF/InstrF change to 0x3004/0x24210002 -> outputs stay at case 1 values; EN=1 -> InstrD=0x24210002, PCD=0x3004.
3. PCF=0x3002 (misaligned), then PCF=0x5000 (out of range) -> each edge: InstrD=0, ExcCodeD=4, ValidD=1, PCD equals the faulting PC.
4. Req=1 together with EN=0 and PCF=0x3010 -> InstrD=0, PCD=0x4180, ValidD=0, isBDD=0 (Req overrides stall).
5. ERETFlush=1, EN=1, PCF=0x3020, isBDF=1 -> InstrD=0, PCD=0x3020, isBDD=0, ValidD=0. Repeat with EN=0 -> registers hold, no flush.
6. Normal load with isBDF=1 -> isBDD=1. Assert reset asynchronously mid-cycle -> all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID stage, CP0 and the next-PC logic:
// exception codes plus the reset and handler addresses.
package if_id_reg_pkg;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // PC after reset and exception-handler entry point
  localparam logic [31:0] START_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // Legal instruction-memory byte range
  localparam logic [31:0] IM_LO = 32'h0000_3000;
  localparam logic [31:0] IM_HI = 32'h0000_4FFF;

endpackage

// File: rtl/if_id_reg_fetch_exc_check.sv
// Word-address legality check. Flags misaligned or out-of-range
// addresses with a configurable code, so the M stage can reuse it
// for data accesses with its own bounds and AdES/AdEL code.
import if_id_reg_pkg::*;

module fetch_exc_check #(
  parameter logic [31:0] LO       = IM_LO,
  parameter logic [31:0] HI       = IM_HI,
  parameter logic [4:0]  EXC_CODE = EXC_ADEL
) (
  input  logic [31:0] addr,
  output logic [4:0]  exc_code
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (addr[1:0] != 2'b00);
  assign out_of_range = (addr < LO) || (addr > HI);

  // Report the configured code on any violation, none otherwise
  always_comb begin
    exc_code = EXC_NONE;
    if (misaligned || out_of_range) begin
      exc_code = EXC_CODE;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches the fetched instruction and PC into
// Decode, tags fetch address errors, and carries the delay-slot flag.
// Handles stall hold, exception-entry flush and ERET flush.
import if_id_reg_pkg::*;

module if_id_reg #(
  parameter logic [31:0] START_PC_P   = START_PC,
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC,
  parameter logic [31:0] IM_LO_P      = IM_LO,
  parameter logic [31:0] IM_HI_P      = IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        Req,
  input  logic        ERETFlush,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  input  logic        isBDF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC8D,
  output logic [4:0]  ExcCodeD,
  output logic        isBDD,
  output logic        ValidD
);

  logic [4:0] exc_code_f;

  fetch_exc_check #(
    .LO       (IM_LO_P),
    .HI       (IM_HI_P),
    .EXC_CODE (EXC_ADEL)
  ) u_fetch_exc_check (
    .addr     (PCF),
    .exc_code (exc_code_f)
  );

  // Stage register: reset > exception entry > stall > ERET flush > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= 32'd0;
      PCD      <= START_PC_P;
      ExcCodeD <= EXC_NONE;
      isBDD    <= 1'b0;
      ValidD   <= 1'b0;
    end else if (Req) begin
      // Exception entry wins even over a stall
      InstrD   <= 32'd0;
      PCD      <= HANDLER_PC_P;
      ExcCodeD <= EXC_NONE;
      isBDD    <= 1'b0;
      ValidD   <= 1'b0;
    end else if (EN) begin
      if (ERETFlush) begin
        // Bubble keeps the fetch PC so a later EPC is still sensible
        InstrD   <= 32'd0;
        PCD      <= PCF;
        ExcCodeD <= EXC_NONE;
        isBDD    <= 1'b0;
        ValidD   <= 1'b0;
      end else begin
        // Never forward data read from an illegal address
        InstrD   <= (exc_code_f != EXC_NONE) ? 32'd0 : InstrF;
        PCD      <= PCF;
        ExcCodeD <= exc_code_f;
        isBDD    <= isBDF;
        ValidD   <= 1'b1;
      end
    end
  end

  // Link address for jal/jalr, derived only from the registered PC
  assign PC8D = PCD + 32'd8;

endmodule
